camera_control: RTL and testbench
=================================

Name: camera_control

Overview:
Turns the four push-buttons and the slide switches into a camera pose for the ray marcher: position (x, y, z) and orientation (yaw, pitch), plus the fractal select.
Successor to the fixed-mode user-control stub, adding:
- parametrised pose widths;
- per-button debouncing;
- selectable step size;
- saturation and wrap rules;
- frame-aligned updates, so the renderer never sees the pose change mid-frame.

Sits between the board I/O and the ray generator. Pose outputs feed the per-pixel ray setup.

Parameters:
- POS_BITS, 16, width of each signed two's-complement position output (Q8.8 at default).
- ANG_BITS, 8, width of the unsigned yaw/pitch angle outputs (full turn = 2^ANG_BITS).
- PITCH_LIMIT, 56, maximum pitch magnitude; pitch is kept in [-PITCH_LIMIT, +PITCH_LIMIT], interpreted as signed.
- DEBOUNCE_CYCLES, 650000, consecutive stable cycles required before a button state is accepted.
- ACCEL_FRAMES, 16, consecutive held frames before the step doubles (optional feature only).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- btnl, btnr, btnu, btnd  input  1 each  raw, asynchronous push-buttons
- sw  input  16  slide switches:
  - [1:0] mode: 0 = translate XY, 1 = translate XZ, 2 = rotate, 3 = hold;
  - [4:2] step shift;
  - [12] home;
  - [15:13] fractal select.
- frame_start  input  1  one-cycle pulse at the start of each rendered frame
- cam_x, cam_y, cam_z  output  POS_BITS each  signed camera position
- cam_yaw, cam_pitch  output  ANG_BITS each  camera angles (pitch signed)
- fractal_sel  output  3  registered fractal select
- cam_update  output  1  one-cycle pulse when outputs were refreshed

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-high on rst_in.
- Reset values: all pose outputs 0, fractal_sel 0, cam_update 0, debounced buttons 0, debounce counters 0, accel counters 0.
- Input synchronisation: each button and sw passes through a 2-flop synchroniser.
- Debounce: per button, a counter clears whenever the synchronised input equals the current debounced state. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced state flips and the counter clears.
- Update timing: pose changes only on the cycle after frame_start. Outputs are registered. cam_update pulses in that same cycle, every frame, even when nothing changed. No other cycle may change the outputs.
- Step size: step = 1 << sw[4:2], zero-extended to POS_BITS (or ANG_BITS for angles).
- Held-button effect: per frame, each debounced-held button contributes one step. Buttons are paired: l/r, u/d.
  - Both buttons of a pair held: that pair contributes 0.
- Mode 0 (translate XY): r → x+step, l → x−step, u → y+step, d → y−step.
- Mode 1 (translate XZ): l/r act on x as in mode 0; u → z+step, d → z−step.
- Mode 2 (rotate): r/l → yaw ±step, wrapping modulo 2^ANG_BITS. u/d → pitch ±step, saturating at ±PITCH_LIMIT.
- Mode 3 (hold): no pose change. cam_update still pulses.
- Position arithmetic: computed at POS_BITS+1 bits and saturated to the signed range [−2^(POS_BITS−1), 2^(POS_BITS−1)−1]. Position never wraps.
- Home: sw[12] high at frame_start forces all pose outputs to 0 and overrides the buttons. The accel counters also clear.
- fractal_sel: takes sw[15:13] at the same frame-aligned update, not continuously.
- Mode change: a change in sw[1:0] mid-frame takes effect at the next frame_start.
- Reset during operation: reset asserted mid-frame clears everything immediately (asynchronous). The first frame_start after release produces a normal update from the zero pose.
- frame_start on consecutive cycles: each pulse causes its own update.

Optional Feature:
- Macro: USER_CONTROL_ACCEL_EN.
- With the macro defined: each button keeps a held-frame counter, saturating at ACCEL_FRAMES, cleared on release or home. While the counter equals ACCEL_FRAMES, the effective step shift is sw[4:2]+1, capped at 7.
- Without the macro: the step shift is always sw[4:2]. No counters are instantiated.

Test Plan:
- Reset then release:
  - All outputs read 0.
  - The first frame_start with no buttons held gives one cam_update pulse and the pose stays 0.
- Debounce, using DEBOUNCE_CYCLES=8 in the bench:
  - btnr toggling every 3 cycles for 40 cycles, then held low, produces no pose change.
  - btnr held 20 cycles, then frame_start with mode 0 and sw[4:2]=2, gives cam_x=4 one cycle after frame_start.
- Saturation and wrap:
  - With cam_x preloaded to 32760 via repeated frames, step 8 with btnr held saturates cam_x at 32767.
  - In mode 2, with yaw at 252, step 8 and btnr held, yaw reads 4.
  - btnu held 20 frames at step 8 clamps pitch at 56.
- Opposite buttons: btnl and btnr both held in mode 0 for 5 frames → cam_x unchanged, cam_update pulses 5 times.
- Home and fractal: sw[12]=1 with btnu held at frame_start → all pose 0. Setting sw[15:13]=5 mid-frame → fractal_sel stays at its old value until the cycle after the next frame_start, then reads 5.
- Acceleration (with USER_CONTROL_ACCEL_EN, ACCEL_FRAMES=4): btnr held, step shift 0:
  - frames 1–4 add 1 each;
  - frame 5 onward adds 2;
  - cam_x after 6 frames = 8.

Source files
------------

// File: rtl/camera_control.sv
// camera_control: debounced push-buttons and switches turned into a frame-aligned camera pose.
// Optional build macro USER_CONTROL_ACCEL_EN doubles the step for buttons held ACCEL_FRAMES frames.
module camera_control #(
  parameter int POS_BITS        = 16,
  parameter int ANG_BITS        = 8,
  parameter int PITCH_LIMIT     = 56,
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int ACCEL_FRAMES    = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                btnl,
  input  logic                btnr,
  input  logic                btnu,
  input  logic                btnd,
  input  logic [15:0]         sw,
  input  logic                frame_start,
  output logic [POS_BITS-1:0] cam_x,
  output logic [POS_BITS-1:0] cam_y,
  output logic [POS_BITS-1:0] cam_z,
  output logic [ANG_BITS-1:0] cam_yaw,
  output logic [ANG_BITS-1:0] cam_pitch,
  output logic [2:0]          fractal_sel,
  output logic                cam_update
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic signed [POS_BITS:0]   POS_MAX  = {2'b00, {(POS_BITS-1){1'b1}}};
  localparam logic signed [POS_BITS:0]   POS_MIN  = {2'b11, {(POS_BITS-1){1'b0}}};
  localparam logic signed [ANG_BITS+1:0] PITCH_HI = (ANG_BITS+2)'(PITCH_LIMIT);

  // Button index order used throughout: 0 = left, 1 = right, 2 = up, 3 = down.
  logic [3:0]  btn_s1_q, btn_s2_q;
  logic [15:0] sw_s1_q, sw_s2_q;

  logic [DB_W-1:0] db_cnt_q [4];
  logic [DB_W-1:0] db_cnt_d [4];
  logic [3:0]      btn_db_q, btn_db_d;

  logic [POS_BITS-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [ANG_BITS-1:0] yaw_q, yaw_d, pitch_q, pitch_d;
  logic [2:0]          fsel_q, fsel_d;
  logic                upd_q, upd_d;

  logic [3:0]          boost;
  logic [2:0]          shift   [4];
  logic [POS_BITS-1:0] pstep   [4];
  logic [ANG_BITS-1:0] astep   [4];

  logic signed [POS_BITS:0]   h_pos, v_pos;
  logic signed [ANG_BITS+1:0] h_ang, v_ang;

  logic [1:0] mode;
  logic       home;
  logic       sw_unused;

  assign mode      = sw_s2_q[1:0];
  assign home      = sw_s2_q[12];
  assign sw_unused = ^sw_s2_q[11:5];

  function automatic logic [2:0] boost_shift(input logic [2:0] base, input logic up);
    if (up && (base != 3'd7)) return base + 3'd1;
    return base;
  endfunction

  function automatic logic [POS_BITS-1:0] sat_pos(input logic [POS_BITS-1:0] p,
                                                  input logic signed [POS_BITS:0] d);
    logic signed [POS_BITS:0] s;
    s = $signed({p[POS_BITS-1], p}) + d;
    if (s > POS_MAX)      s = POS_MAX;
    else if (s < POS_MIN) s = POS_MIN;
    return s[POS_BITS-1:0];
  endfunction

  function automatic logic [ANG_BITS-1:0] clamp_pitch(input logic [ANG_BITS-1:0] p,
                                                      input logic signed [ANG_BITS+1:0] d);
    logic signed [ANG_BITS+1:0] s;
    s = $signed({{2{p[ANG_BITS-1]}}, p}) + d;
    if (s > PITCH_HI)       s = PITCH_HI;
    else if (s < -PITCH_HI) s = -PITCH_HI;
    return s[ANG_BITS-1:0];
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= {btnd, btnu, btnr, btnl};
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // A button flips only after DEBOUNCE_CYCLES consecutive cycles disagreeing with its accepted state.
  always_comb begin
    btn_db_d = btn_db_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (btn_s2_q[i] == btn_db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        btn_db_d[i] = ~btn_db_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      btn_db_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      btn_db_q <= btn_db_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

`ifdef USER_CONTROL_ACCEL_EN
  localparam int AC_W = $clog2(ACCEL_FRAMES + 1);
  localparam logic [AC_W-1:0] AC_MAX = AC_W'(ACCEL_FRAMES);

  logic [AC_W-1:0] acc_cnt_q [4];
  logic [AC_W-1:0] acc_cnt_d [4];

  // Counts frames a button has been held; the boost applies from the frame after it saturates.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      acc_cnt_d[i] = acc_cnt_q[i];
      boost[i]     = (acc_cnt_q[i] == AC_MAX);
      if (frame_start && home)
        acc_cnt_d[i] = '0;
      else if (!btn_db_q[i])
        acc_cnt_d[i] = '0;
      else if (frame_start && (acc_cnt_q[i] != AC_MAX))
        acc_cnt_d[i] = acc_cnt_q[i] + AC_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 4; i++) acc_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) acc_cnt_q[i] <= acc_cnt_d[i];
    end
  end
`else
  localparam int ACCEL_UNUSED = ACCEL_FRAMES;
  assign boost = '0;
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      shift[i] = boost_shift(sw_s2_q[4:2], boost[i]);
      pstep[i] = POS_BITS'(1) << shift[i];
      astep[i] = ANG_BITS'(1) << shift[i];
    end
  end

  // Opposing buttons of a pair cancel; each direction uses its own button's step.
  always_comb begin
    h_pos = '0;
    v_pos = '0;
    h_ang = '0;
    v_ang = '0;
    if (btn_db_q[1] && !btn_db_q[0]) begin
      h_pos = $signed({1'b0, pstep[1]});
      h_ang = $signed({2'b00, astep[1]});
    end else if (btn_db_q[0] && !btn_db_q[1]) begin
      h_pos = -$signed({1'b0, pstep[0]});
      h_ang = -$signed({2'b00, astep[0]});
    end
    if (btn_db_q[2] && !btn_db_q[3]) begin
      v_pos = $signed({1'b0, pstep[2]});
      v_ang = $signed({2'b00, astep[2]});
    end else if (btn_db_q[3] && !btn_db_q[2]) begin
      v_pos = -$signed({1'b0, pstep[3]});
      v_ang = -$signed({2'b00, astep[3]});
    end
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    yaw_d   = yaw_q;
    pitch_d = pitch_q;
    fsel_d  = fsel_q;
    upd_d   = 1'b0;
    if (frame_start) begin
      upd_d  = 1'b1;
      fsel_d = sw_s2_q[15:13];
      if (home) begin
        x_d     = '0;
        y_d     = '0;
        z_d     = '0;
        yaw_d   = '0;
        pitch_d = '0;
      end else begin
        case (mode)
          2'd0: begin
            x_d = sat_pos(x_q, h_pos);
            y_d = sat_pos(y_q, v_pos);
          end
          2'd1: begin
            x_d = sat_pos(x_q, h_pos);
            z_d = sat_pos(z_q, v_pos);
          end
          2'd2: begin
            yaw_d   = yaw_q + h_ang[ANG_BITS-1:0];
            pitch_d = clamp_pitch(pitch_q, v_ang);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      yaw_q   <= '0;
      pitch_q <= '0;
      fsel_q  <= '0;
      upd_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      yaw_q   <= yaw_d;
      pitch_q <= pitch_d;
      fsel_q  <= fsel_d;
      upd_q   <= upd_d;
    end
  end

  assign cam_x       = x_q;
  assign cam_y       = y_q;
  assign cam_z       = z_q;
  assign cam_yaw     = yaw_q;
  assign cam_pitch   = pitch_q;
  assign fractal_sel = fsel_q;
  assign cam_update  = upd_q;

endmodule

// File: tb/tb_camera_control.sv
// Bench for camera_control: directed corner cases plus random frames against a pose model.
module tb_camera_control;

  localparam int PB = 16;
  localparam int AB = 8;
  localparam int PL = 56;
  localparam int DB = 8;
  localparam int AF = 4;
  localparam int PMAX = (1 << (PB - 1)) - 1;
  localparam int PMIN = -(1 << (PB - 1));
`ifdef USER_CONTROL_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          btnl, btnr, btnu, btnd;
  logic [15:0]   sw;
  logic          frame_start;
  logic [PB-1:0] cam_x, cam_y, cam_z;
  logic [AB-1:0] cam_yaw, cam_pitch;
  logic [2:0]    fractal_sel;
  logic          cam_update;

  camera_control #(
    .POS_BITS(PB), .ANG_BITS(AB), .PITCH_LIMIT(PL),
    .DEBOUNCE_CYCLES(DB), .ACCEL_FRAMES(AF)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .btnl(btnl), .btnr(btnr), .btnu(btnu), .btnd(btnd),
    .sw(sw), .frame_start(frame_start),
    .cam_x(cam_x), .cam_y(cam_y), .cam_z(cam_z),
    .cam_yaw(cam_yaw), .cam_pitch(cam_pitch),
    .fractal_sel(fractal_sel), .cam_update(cam_update)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int upd_cnt  = 0;

  int m_x, m_y, m_z, m_yaw, m_pitch, m_fsel;
  int m_acc [4];

  always @(negedge clk) if (cam_update === 1'b1) upd_cnt++;

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_z = 0; m_yaw = 0; m_pitch = 0; m_fsel = 0;
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // One frame's effect of the currently held (settled) buttons and switches.
  task automatic model_frame();
    bit b [4];
    int st [4];
    int h, v, sh;
    b[0] = btnl; b[1] = btnr; b[2] = btnu; b[3] = btnd;
    for (int i = 0; i < 4; i++) begin
      sh = int'(sw[4:2]) + ((ACCEL_ON && m_acc[i] >= AF) ? 1 : 0);
      if (sh > 7) sh = 7;
      st[i] = 1 << sh;
    end
    h = (b[1] && !b[0]) ? st[1] : ((b[0] && !b[1]) ? -st[0] : 0);
    v = (b[2] && !b[3]) ? st[2] : ((b[3] && !b[2]) ? -st[3] : 0);
    m_fsel = int'(sw[15:13]);
    if (sw[12]) begin
      m_x = 0; m_y = 0; m_z = 0; m_yaw = 0; m_pitch = 0;
      for (int i = 0; i < 4; i++) m_acc[i] = 0;
    end else begin
      case (sw[1:0])
        2'd0: begin m_x = clampi(m_x + h, PMIN, PMAX); m_y = clampi(m_y + v, PMIN, PMAX); end
        2'd1: begin m_x = clampi(m_x + h, PMIN, PMAX); m_z = clampi(m_z + v, PMIN, PMAX); end
        2'd2: begin
          m_yaw   = ((m_yaw + h) % (1 << AB) + (1 << AB)) % (1 << AB);
          m_pitch = clampi(m_pitch + v, -PL, PL);
        end
        default: ;
      endcase
      for (int i = 0; i < 4; i++) m_acc[i] = b[i] ? ((m_acc[i] < AF) ? m_acc[i] + 1 : AF) : 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_x"},     $signed(cam_x),     m_x);
    check({tag, "_y"},     $signed(cam_y),     m_y);
    check({tag, "_z"},     $signed(cam_z),     m_z);
    check({tag, "_yaw"},   cam_yaw,            m_yaw);
    check({tag, "_pitch"}, $signed(cam_pitch), m_pitch);
    check({tag, "_fsel"},  fractal_sel,        m_fsel);
  endtask

  // Non-frame cycles: nothing may move.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_upd",  cam_update,  0);
      check("idle_x",    $signed(cam_x), m_x);
      check("idle_yaw",  cam_yaw,     m_yaw);
      check("idle_fsel", fractal_sel, m_fsel);
    end
  endtask

  // n back-to-back frame_start pulses, each checked on the cycle after.
  task automatic frames(input int n, input string tag);
    frame_start = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == n - 1) frame_start = 1'b0;
      model_frame();
      check({tag, "_upd"}, cam_update, 1);
      check_all(tag);
    end
  endtask

  task automatic set_in(input logic [3:0] b, input int mode, input int sh,
                        input bit home, input int fs);
    btnl = b[0]; btnr = b[1]; btnu = b[2]; btnd = b[3];
    sw[1:0]   = 2'(mode);
    sw[4:2]   = 3'(sh);
    sw[11:5]  = 7'($urandom);
    sw[12]    = home;
    sw[15:13] = 3'(fs);
    idle(16);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    rst = 1'b1;
    btnl = 0; btnr = 0; btnu = 0; btnd = 0;
    sw = '0;
    frame_start = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_x",   $signed(cam_x), 0);
    check("rst_y",   $signed(cam_y), 0);
    check("rst_z",   $signed(cam_z), 0);
    check("rst_yaw", cam_yaw, 0);
    check("rst_pit", cam_pitch, 0);
    check("rst_fs",  fractal_sel, 0);
    check("rst_upd", cam_update, 0);
    rst = 1'b0;
    idle(4);
    frames(1, "first");
    check("first_x0", $signed(cam_x), 0);

    // Bounce shorter than the debounce window must not register.
    for (int k = 0; k < 40; k++) begin
      btnr = ((k / 3) % 2) != 0;
      @(negedge clk);
    end
    btnr = 1'b0;
    idle(16);
    frames(1, "bounce");

    set_in(4'b0010, 0, 2, 0, 0);
    idle(4);
    frames(1, "deb");
    check("deb_x4", $signed(cam_x), 4);

    // Positive and negative position saturation.
    set_in(4'b0000, 0, 0, 1, 0);
    frames(1, "home0");
    set_in(4'b0010, 0, 7, 0, 0);
    frames(255, "pre7");
    set_in(4'b0010, 0, 6, 0, 0); frames(1, "pre6");
    set_in(4'b0010, 0, 5, 0, 0); frames(1, "pre5");
    set_in(4'b0010, 0, 4, 0, 0); frames(1, "pre4");
    set_in(4'b0010, 0, 3, 0, 0); frames(1, "pre3");
    frames(1, "sat_hi");
    check("sat_hi_x", $signed(cam_x), PMAX);
    set_in(4'b0000, 0, 0, 1, 0);
    frames(1, "home1");
    set_in(4'b0001, 0, 7, 0, 0);
    frames(257, "sat_lo");
    check("sat_lo_x", $signed(cam_x), PMIN);

    // Yaw wrap and pitch clamp.
    set_in(4'b0000, 2, 0, 1, 0);
    frames(1, "home2");
    set_in(4'b0001, 2, 2, 0, 0);
    frames(1, "yaw252");
    check("yaw252", cam_yaw, 252);
    set_in(4'b0010, 2, 3, 0, 0);
    frames(1, "yawwrap");
    check("yaw_wrap4", cam_yaw, 4);
    set_in(4'b0100, 2, 3, 0, 0);
    frames(20, "pitch_up");
    check("pitch_hi", $signed(cam_pitch), PL);
    set_in(4'b1000, 2, 3, 0, 0);
    frames(20, "pitch_dn");
    check("pitch_lo", $signed(cam_pitch), -PL);

    // Opposing buttons cancel; every frame still pulses.
    set_in(4'b0011, 0, 4, 0, 0);
    c0 = upd_cnt;
    for (int k = 0; k < 5; k++) begin
      frames(1, "opp");
      idle(3);
    end
    check("opp_pulses", upd_cnt - c0, 5);

    // Home overrides held buttons; fractal select is frame-aligned.
    set_in(4'b0100, 0, 3, 1, 2);
    frames(1, "home_btn");
    check("home_y", $signed(cam_y), 0);
    sw[12] = 1'b0;
    btnu = 1'b0;
    idle(16);
    sw[15:13] = 3'd5;
    idle(10);
    check("fsel_old", fractal_sel, 2);
    frames(1, "fsel");
    check("fsel_new", fractal_sel, 5);

`ifdef USER_CONTROL_ACCEL_EN
    set_in(4'b0000, 0, 0, 1, 0);
    frames(1, "home_acc");
    set_in(4'b0010, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) frames(1, "acc_a");
    check("acc_x4", $signed(cam_x), 4);
    for (int k = 0; k < 2; k++) frames(1, "acc_b");
    check("acc_x8", $signed(cam_x), 8);
`endif

    // Asynchronous reset mid-frame, then a normal update from zero.
    set_in(4'b0001, 0, 5, 0, 0);
    frames(2, "pre_rst");
    idle(3);
    rst = 1'b1;
    #1;
    check("arst_x",   $signed(cam_x), 0);
    check("arst_yaw", cam_yaw, 0);
    check("arst_fs",  fractal_sel, 0);
    check("arst_upd", cam_update, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(16);
    frames(1, "post_rst");
    check("post_rst_x", $signed(cam_x), -32);

    // Random frames.
    for (int it = 0; it < 80; it++) begin
      set_in(4'($urandom), $urandom_range(0, 3), $urandom_range(0, 7),
             ($urandom_range(0, 9) == 0), $urandom_range(0, 7));
      frames($urandom_range(1, 3), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
